// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The master side issues operands and consumes results; the slave side is the adder.
interface cla_nibble_sequencer_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial wide adder: one 4-bit carry-lookahead slice is reused once per
// clock, least significant nibble first, with the slice carry rippled through a
// register. The finished sum is held with a valid/ready handshake until taken.
module cla_nibble_sequencer #(
  parameter int NIB = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cla_nibble_sequencer_if.slave   bus
);
  localparam int W     = 4 * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_r, b_r;
  logic [W-1:0]       sum_r;
  logic               carry_r;
  logic               msb_cin_r;
  logic [IDX_W-1:0]   idx;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               accept;
  logic [W-1:0]       a_sh, b_sh;
  logic [5:0]         slice;

  // Combinational 4-bit carry-lookahead slice; returns {c4, c3, s[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] p, g, c, s;
    logic       c4;
    p    = x ^ y;
    g    = x & y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c;
    return {c4, c[3], s};
  endfunction

  // Current nibble of each operand, selected by shifting the held operand down.
  assign a_sh   = a_r >> {idx, 2'b00};
  assign b_sh   = b_r >> {idx, 2'b00};
  assign slice  = cla4(a_sh[3:0], b_sh[3:0], carry_r);
  assign accept = in_ready_c & bus.in_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; both handshake outputs depend on state only.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept; operands are don't-care until then.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
    end
  end

  // Per-nibble accumulation: write the slice sum, ripple the carry, step idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r     <= '0;
      carry_r   <= 1'b0;
      msb_cin_r <= 1'b0;
      idx       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_r     <= '0;
            carry_r   <= bus.cin;
            msb_cin_r <= 1'b0;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDX_W'(i)) sum_r[4*i +: 4] <= slice[3:0];
          end
          carry_r <= slice[5];
          if (idx == LAST_IDX) msb_cin_r <= slice[4];
          else                 idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_r;
  assign bus.cout      = carry_r;
  assign bus.ovf       = msb_cin_r ^ carry_r;
  assign bus.zero      = (sum_r == '0);
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for the nibble-serial CLA adder: a 4-nibble and a 1-nibble instance,
// with a results scoreboard fed at operand issue and drained at result transfer.
module tb_cla_nibble_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_nibble_sequencer_if #(.NIB(4)) bus4();
  cla_nibble_sequencer_if #(.NIB(1)) bus1();

  cla_nibble_sequencer #(.NIB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  cla_nibble_sequencer #(.NIB(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition truncated to w bits, overflow from sign rules.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin);
    logic [16:0] full;
    logic [16:0] mask;
    exp_t        r;
    mask   = (17'h1 << w) - 17'h1;
    full   = {1'b0, a} + {1'b0, b} + {16'h0, cin};
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    r.zero = (r.sum == 16'h0);
    return r;
  endfunction

  // Scoreboard drain: compare at the falling edge before each transfer edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) check_eq("sb4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        check_eq("sum4", {16'h0, bus4.sum}, {16'h0, e.sum});
        check_eq("cout4", {31'h0, bus4.cout}, {31'h0, e.cout});
        check_eq("ovf4", {31'h0, bus4.ovf}, {31'h0, e.ovf});
        check_eq("zero4", {31'h0, bus4.zero}, {31'h0, e.zero});
      end
    end
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) check_eq("sb1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        check_eq("sum1", {28'h0, bus1.sum}, {28'h0, e.sum[3:0]});
        check_eq("cout1", {31'h0, bus1.cout}, {31'h0, e.cout});
        check_eq("ovf1", {31'h0, bus1.ovf}, {31'h0, e.ovf});
        check_eq("zero1", {31'h0, bus1.zero}, {31'h0, e.zero});
      end
    end
  end

  // Issue one operation on the 4-nibble adder, optionally scrambling operands
  // during RUN and holding off the consumer for 'hold' cycles.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input bit scramble, input int hold);
    int          n;
    logic [31:0] r;
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus4.in_ready) check_eq("in_ready_timeout4", 0, 1);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    q4.push_back(model(16, a, b, cin));
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    check_eq("in_ready_run4", {31'h0, bus4.in_ready}, 0);
    n = 0;
    while (!bus4.out_valid && n < 40) begin
      if (scramble) begin
        r = $urandom; bus4.a = r[15:0]; bus4.b = r[31:16]; bus4.cin = r[0];
      end
      @(posedge clk); #1; n++;
    end
    check_eq("latency4", n, 4);
    for (int i = 0; i < hold; i++) begin
      check_eq("bp_valid", {31'h0, bus4.out_valid}, 1);
      check_eq("bp_in_ready", {31'h0, bus4.in_ready}, 0);
      check_eq("bp_sum", {16'h0, bus4.sum}, {16'h0, q4[0].sum});
      r = $urandom;
      bus4.in_valid = ~bus4.in_valid; bus4.a = r[15:0]; bus4.b = r[31:16];
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check_eq("in_ready_after_xfer4", {31'h0, bus4.in_ready}, 1);
    check_eq("valid_drop4", {31'h0, bus4.out_valid}, 0);
  endtask

  // Issue one operation on the 1-nibble adder.
  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int n;
    n = 0;
    while (!bus1.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus1.in_ready) check_eq("in_ready_timeout1", 0, 1);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.in_valid = 1'b1;
    q1.push_back(model(4, {12'h0, a}, {12'h0, b}, cin));
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check_eq("latency1", n, 1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check_eq("in_ready_after_xfer1", {31'h0, bus1.in_ready}, 1);
  endtask

  initial begin
    int          seen;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'h0, bus4.in_ready}, 1);
    check_eq("rst_out_valid", {31'h0, bus4.out_valid}, 0);
    check_eq("rst_sum", {16'h0, bus4.sum}, 0);
    check_eq("rst_zero", {31'h0, bus4.zero}, 1);
    check_eq("rst_cout", {31'h0, bus4.cout}, 0);
    check_eq("rst_ovf", {31'h0, bus4.ovf}, 0);
    check_eq("rst_in_ready1", {31'h0, bus1.in_ready}, 1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_in_ready", {31'h0, bus4.in_ready}, 1);
    check_eq("idle_out_valid", {31'h0, bus4.out_valid}, 0);

    op4(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
    op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    op4(16'h00F0, 16'h0F10, 1'b0, 1'b0, 5);
    op4(16'h8000, 16'h8000, 1'b0, 1'b1, 0);

    // Abort an operation in its second RUN cycle.
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_in_ready", {31'h0, bus4.in_ready}, 1);
    check_eq("abort_out_valid", {31'h0, bus4.out_valid}, 0);
    check_eq("abort_sum", {16'h0, bus4.sum}, 0);
    check_eq("abort_cout", {31'h0, bus4.cout}, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_result", seen, 0);

    op4(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

    op1(4'hF, 4'h1, 1'b0);
    op1(4'h7, 4'h1, 1'b0);
    op1(4'h5, 4'h9, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb4_drained", q4.size(), 0);
    check_eq("sb1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide adder that computes a (4·NIB)-bit sum by running one 4-bit carry-lookahead slice per clock, least significant nibble first, and rippling the slice carry through a register. It sits directly upstream of the result consumer and around the 4-bit CLA datapath. It takes operands through a valid/ready handshake and feeds nibble operands plus the registered carry into the slice. It collects the slice sums and carries into a held result with its own valid/ready handshake. It trades latency for area: one CLA slice serves any operand width.

## Interface
Parameters:
- NIB, 4, number of 4-bit nibbles; operand width W = 4·NIB; legal range 1..16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset (sampled on clk rising edge).
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand set.
- a  in  W  operand A, unsigned or two's complement.
- b  in  W  operand B.
- cin  in  1  carry into nibble 0.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  a + b + cin, modulo 2^W.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- Slice: combinational 4-bit CLA. p = a^b and g = a&b per bit. c1 = g0|p0c0, c2 = g1|p1g0|p1p0c0, and so on up to c4. s = p ^ {c3..c0}. The slice also produces its MSB carry-in c3 for the overflow computation.
- FSM states are IDLE, RUN, and DONE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - latch a and b into operand registers;
  - set carry_r = cin;
  - set idx = 0;
  - clear the sum register;
  - go to RUN.
- RUN: in_ready = 0. Each cycle the slice adds nibble idx of A and B with carry_r:
  - sum[4·idx+3:4·idx] <= slice sum;
  - carry_r <= c4;
  - when idx == NIB-1, also capture c3 as msb_cin_r;
  - idx increments.
- RUN exits after nibble NIB-1 is written: go to DONE; idx does not wrap.
- DONE outputs:
  - out_valid = 1;
  - cout = carry_r;
  - ovf = msb_cin_r ^ carry_r;
  - zero = (sum == 0).
  - On out_ready, go to IDLE and drop out_valid on the next cycle.
- Outputs sum, cout, ovf, and zero are registered/derived from registers. They stay stable from out_valid rise until the transfer.
- Inputs a, b, and cin are ignored outside the IDLE accept cycle; changing them during RUN has no effect.
- in_valid outside IDLE is ignored (not queued).
- idx width is clog2(NIB), minimum 1 bit. For NIB = 1, RUN lasts exactly one cycle.

## Timing
- Reset (rst_n = 0 at a rising edge) gives:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - sum = 0, cout = 0, ovf = 0, zero = 1;
  - idx = 0, carry_r = 0.
- Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- Latency: accept at edge k, then out_valid = 1 after edge k+NIB. For NIB = 4, accept at edge k gives out_valid after edge k+4.
- Transfer at edge m (out_valid & out_ready) gives in_ready = 1 after edge m. The next accept is possible at edge m+1.
- Throughput: one result per NIB+2 cycles with no backpressure.
- Backpressure: out_ready low holds DONE and all outputs indefinitely, with in_ready = 0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- NIB=4, reset: hold rst_n low 3 cycles -> in_ready=1, out_valid=0, sum=0x0000, zero=1. Release -> no state change without in_valid.
- A=0x1234, B=0x4321, cin=1 -> exactly 4 cycles after accept: sum=0x5556, cout=0, ovf=0, zero=0.
- A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1. This checks the full carry chain across all nibbles. Then A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Backpressure: A=0x00F0, B=0x0F10, out_ready low 5 cycles after out_valid -> sum=0x1000 held stable, in_ready=0, in_valid pulses ignored. out_ready high -> transfer; in_ready=1 next cycle.
- Operand change: after accepting A=0x8000, B=0x8000, drive a/b to random values during RUN -> sum=0x0000, cout=1, ovf=1.
- Reset mid-op: assert rst_n low in the second RUN cycle -> reset values next cycle, no out_valid. A following op A=0x0003, B=0x0004 -> sum=0x0007 with normal latency. Repeat the full-chain case with NIB=1 (A=0xF, B=0x1 -> sum=0x0, cout=1, latency 1).
